dummy_accelerator_issue_ctrl: RTL

Issue scheduler placed between the CPU coprocessor request path and dummy_accelerator_top. It tracks the number of in-flight operations and enforces the mode-exclusivity rule in hardware: an op of a different ctl mode (ITERATIVE vs PIPELINE) is held until every outstanding op of the current mode has completed. It also caps outstanding ops, drops illegal ctl codes with an error pulse, and clears state on flush.

---
 rtl/dummy_accelerator_pkg.sv | 14 +
 rtl/dummy_accelerator_issue_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dummy_accelerator_pkg.sv
// Shared types for the dummy accelerator and its issue controller.
// ctl_type_t is the operation control code carried with every request.
// Only ITERATIVE and PIPELINE are legal; the two remaining encodings are
// reserved, and the issue controller drops them.
package dummy_accelerator_pkg;

    typedef enum logic [1:0] {
        EU_CTL_ITERATIVE = 2'd0,
        EU_CTL_PIPELINE  = 2'd1,
        EU_CTL_RSVD2     = 2'd2,
        EU_CTL_RSVD3     = 2'd3
    } ctl_type_t;

endpackage

// File: rtl/dummy_accelerator_issue_ctrl.sv
// dummy_accelerator_issue_ctrl
//
// Issue scheduler between the coprocessor request path and the accelerator.
// It counts in-flight operations, which are ops that have been issued but
// have not completed. It only lets an op of a different ctl mode through
// after every outstanding op of the current mode has completed. It also caps
// the number of in-flight ops, drops reserved ctl codes with an error pulse,
// and clears its state on flush.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous active-high reset; dominates every other input
//   flush_i        synchronous clear; same next state as reset, and it also
//                  ignores late responses until the next issue
//   req_valid_i    upstream op request
//   req_ready_o    upstream accept; also high for a dropped illegal op
//   req_ctl_i      ctl of the requested op
//   acc_valid_o    valid to the accelerator; never depends on acc_ready_i
//   acc_ready_i    accelerator ready
//   acc_ctl_o      ctl to the accelerator; a pass-through of req_ctl_i
//   rsp_valid_i    accelerator result present
//   rsp_ready_i    downstream accepts the result
//   busy_o         scheduler is not idle
//   draining_o     waiting for the current mode to empty before a mode switch
//   mode_o         mode of the ops in flight
//   outstanding_o  in-flight op count
//   err_o          one-cycle pulse for an illegal ctl code or a response
//                  arriving with nothing outstanding
module dummy_accelerator_issue_ctrl
    import dummy_accelerator_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  ctl_type_t            req_ctl_i,
    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output ctl_type_t            acc_ctl_o,
    input  logic                 rsp_valid_i,
    input  logic                 rsp_ready_i,
    output logic                 busy_o,
    output logic                 draining_o,
    output ctl_type_t            mode_o,
    output logic [CNT_WIDTH-1:0] outstanding_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    ctl_type_t            mode_q,  mode_d;
    logic                 err_q,   err_d;
    logic                 ign_q,   ign_d;

    logic legal;
    logic allow;
    logic clr;
    logic illegal_drop;
    logic issue;
    logic done_raw;
    logic done_eff;
    logic done_cnt;
    logic underflow;

    // Request classification and the admission rule. The full check uses the
    // registered count only. A completion in the same cycle therefore never
    // opens the gate combinationally.
    always_comb begin
        legal = (req_ctl_i == EU_CTL_ITERATIVE) || (req_ctl_i == EU_CTL_PIPELINE);
        clr   = rst_i | flush_i;
        allow = (state_q == ST_IDLE) ||
                ((state_q == ST_ACTIVE) && (req_ctl_i == mode_q) && (cnt_q < CNT_MAX));
    end

    // Handshake toward upstream and the accelerator. Reset and flush cycles
    // accept nothing. A drain blocks every request, including illegal ones.
    // Otherwise an illegal code is consumed and dropped without reaching the
    // accelerator.
    always_comb begin
        acc_valid_o  = 1'b0;
        req_ready_o  = 1'b0;
        illegal_drop = 1'b0;
        if (!clr && (state_q != ST_DRAIN)) begin
            if (!legal) begin
                req_ready_o  = 1'b1;
                illegal_drop = req_valid_i;
            end else begin
                acc_valid_o = req_valid_i & allow;
                req_ready_o = acc_ready_i & allow;
            end
        end
    end

    assign acc_ctl_o = req_ctl_i;

    // Completion accounting. After a flush, completions from ops issued before
    // the flush are ignored silently until the next issue. A completion with
    // nothing outstanding is reported as an error and does not touch the
    // count.
    always_comb begin
        issue     = acc_valid_o & acc_ready_i;
        done_raw  = rsp_valid_i & rsp_ready_i;
        done_eff  = done_raw & ~ign_q;
        underflow = done_eff & (cnt_q == CNT_ZERO);
        done_cnt  = done_eff & (cnt_q != CNT_ZERO);
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({issue, done_cnt})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Mode FSM. The mode is latched only on an issue from IDLE. A different
    // mode therefore has to wait in DRAIN until the count reaches zero. It
    // then issues from IDLE on the following cycle.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    mode_d  = req_ctl_i;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if ((cnt_d == CNT_ZERO) && !issue) begin
                    state_d = ST_IDLE;
                end else if (req_valid_i && legal && (req_ctl_i != mode_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        err_d = illegal_drop | underflow;
        ign_d = issue ? 1'b0 : ign_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            mode_q  <= EU_CTL_ITERATIVE;
            err_q   <= 1'b0;
            ign_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            mode_q  <= EU_CTL_ITERATIVE;
            err_q   <= 1'b0;
            ign_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            ign_q   <= ign_d;
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign draining_o    = (state_q == ST_DRAIN);
    assign mode_o        = mode_q;
    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule
